// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code sequencer.
// Key codes, prefix and ignored-byte constants, FSM state encoding
// and a decoder mapping {extended, code} onto the packed {p2, p1} key vector.
package kb_pkg;

  // Player 1: all non-extended
  localparam logic [7:0] KC_P1_UP    = 8'h1D;  // W
  localparam logic [7:0] KC_P1_DOWN  = 8'h1B;  // S
  localparam logic [7:0] KC_P1_LEFT  = 8'h1C;  // A
  localparam logic [7:0] KC_P1_RIGHT = 8'h23;  // D
  localparam logic [7:0] KC_P1_FIRE  = 8'h3B;  // J

  // Player 2: movement is extended (arrow keys), shoot is non-extended
  localparam logic [7:0] KC_P2_UP    = 8'h75;
  localparam logic [7:0] KC_P2_DOWN  = 8'h72;
  localparam logic [7:0] KC_P2_LEFT  = 8'h6B;
  localparam logic [7:0] KC_P2_RIGHT = 8'h74;
  localparam logic [7:0] KC_P2_FIRE  = 8'h4C;  // ;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Keyboard status / pause bytes that carry no key information
  localparam logic [7:0] IGN_E1 = 8'hE1;
  localparam logic [7:0] IGN_AA = 8'hAA;
  localparam logic [7:0] IGN_FA = 8'hFA;
  localparam logic [7:0] IGN_EE = 8'hEE;
  localparam logic [7:0] IGN_FE = 8'hFE;
  localparam logic [7:0] IGN_00 = 8'h00;
  localparam logic [7:0] IGN_FF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  function automatic logic is_ignored(input logic [7:0] code);
    return (code == IGN_E1) || (code == IGN_AA) || (code == IGN_FA) ||
           (code == IGN_EE) || (code == IGN_FE) || (code == IGN_00) ||
           (code == IGN_FF);
  endfunction

  // One-hot mask into {p2[4:0], p1[4:0]}; zero for unmapped codes.
  // The extended flag is part of the match, so bare 75 (keypad 8) misses.
  function automatic logic [9:0] key_mask(input logic [7:0] code, input logic ext);
    logic [9:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        KC_P1_UP:    m[0] = 1'b1;
        KC_P1_DOWN:  m[1] = 1'b1;
        KC_P1_LEFT:  m[2] = 1'b1;
        KC_P1_RIGHT: m[3] = 1'b1;
        KC_P1_FIRE:  m[4] = 1'b1;
        KC_P2_FIRE:  m[9] = 1'b1;
        default:     m = '0;
      endcase
    end else begin
      case (code)
        KC_P2_UP:    m[5] = 1'b1;
        KC_P2_DOWN:  m[6] = 1'b1;
        KC_P2_LEFT:  m[7] = 1'b1;
        KC_P2_RIGHT: m[8] = 1'b1;
        default:     m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/fire_limiter.sv
// Rate limiter turning a held shoot key into periodic single-cycle fire pulses.
// Latency: fire registered one edge after hold is seen with the counter at zero.
// Backpressure: none; the pulse is fire-and-forget.
// Ports: board_clk, reset (async active-low), hold (shoot key held), fire (pulse).
module fire_limiter #(
  parameter int unsigned FIRE_COOLDOWN = 5_000_000,
  parameter int unsigned CD_W          = 24
) (
  input  logic board_clk,
  input  logic reset,
  input  logic hold,
  output logic fire
);

  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN - 1);

  logic [CD_W-1:0] cnt;

  // Releasing hold leaves the counter running, so tapping the key
  // cannot beat the cooldown.
  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      fire <= 1'b0;
    end else if (hold && (cnt == '0)) begin
      cnt  <= CD_LOAD;
      fire <= 1'b1;
    end else begin
      fire <= 1'b0;
      if (cnt != '0) cnt <= cnt - CD_W'(1);
    end
  end

endmodule

// File: rtl/kb_seq_ctrl.sv
// PS/2 Set-2 scan-code sequencer: E0/F0 prefix FSM, per-player held-key vectors, fire limiters.
// Latency: key vectors one edge after the byte strobe; fire one further edge; proto_err one edge.
// Backpressure: none; the receiver cannot be stalled, so every strobed byte is consumed that cycle.
// Ports: board_clk, reset (async active-low), rx_valid/rx_data (byte strobe),
//        p1/p2 (held keys up,down,left,right,shoot), p1_fire/p2_fire, proto_err.
module kb_seq_ctrl
  import kb_pkg::*;
#(
  parameter int unsigned FIRE_COOLDOWN  = 5_000_000,
  parameter int unsigned PREFIX_TIMEOUT = 1_000_000,
  parameter int unsigned CD_W           = 24
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [4:0] p1,
  output logic [4:0] p2,
  output logic       p1_fire,
  output logic       p2_fire,
  output logic       proto_err
);

  localparam logic [CD_W-1:0] TMO_LAST = CD_W'(PREFIX_TIMEOUT - 1);

  kb_state_t       state;
  logic [CD_W-1:0] tmo_cnt;

  always_ff @(posedge board_clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      p1        <= '0;
      p2        <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      if (rx_valid) begin
        tmo_cnt <= '0;
        unique case (state)
          ST_IDLE: begin
            if (rx_data == PFX_EXT)      state <= ST_EXT;
            else if (rx_data == PFX_BRK) state <= ST_BRK;
            else if (!is_ignored(rx_data))
              {p2, p1} <= {p2, p1} | key_mask(rx_data, 1'b0);
          end
          ST_EXT: begin
            // A repeated E0 is flagged but keeps the extended context alive
            if (rx_data == PFX_BRK) begin
              state <= ST_EXT_BRK;
            end else if (rx_data == PFX_EXT) begin
              proto_err <= 1'b1;
            end else begin
              {p2, p1} <= {p2, p1} | key_mask(rx_data, 1'b1);
              state    <= ST_IDLE;
            end
          end
          ST_BRK, ST_EXT_BRK: begin
            state <= ST_IDLE;
            if (rx_data == PFX_EXT || rx_data == PFX_BRK)
              proto_err <= 1'b1;
            else
              {p2, p1} <= {p2, p1} & ~key_mask(rx_data, state == ST_EXT_BRK);
          end
        endcase
      end else if (state != ST_IDLE) begin
        // Abandon a prefix whose follow-up byte never arrives
        if (tmo_cnt == TMO_LAST) begin
          state     <= ST_IDLE;
          tmo_cnt   <= '0;
          proto_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + CD_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  fire_limiter #(
    .FIRE_COOLDOWN (FIRE_COOLDOWN),
    .CD_W          (CD_W)
  ) u_fire_p1 (
    .board_clk (board_clk),
    .reset     (reset),
    .hold      (p1[4]),
    .fire      (p1_fire)
  );

  fire_limiter #(
    .FIRE_COOLDOWN (FIRE_COOLDOWN),
    .CD_W          (CD_W)
  ) u_fire_p2 (
    .board_clk (board_clk),
    .reset     (reset),
    .hold      (p2[4]),
    .fire      (p2_fire)
  );

endmodule
